gshare_pht_ctrl: RTL and testbench



---
 rtl/gshare_pht_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_gshare_pht_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_pht_ctrl.sv
// gshare_pht_ctrl: controller for a 2**IDX_WIDTH x 2-bit pattern history table
// held in an external dual-port SRAM (port 0 write, port 1 read with
// registered address and combinational read data).
//  - After reset, every entry is written with INIT_CTR, because the array
//    itself has no reset. Predictions are not accepted during this sweep.
//  - Predictions index the table with pc-slice XOR GHR. One prediction can be
//    accepted per cycle, and its result appears on the following cycle.
//  - Resolved branches write a saturating-counter update and shift the
//    non-speculative GHR.
// Optional feature macro: PHT_BYPASS_EN. When it is defined, a prediction
// forwards the data of updates accepted in the same cycle or the previous
// cycle, so it never reads a stale counter.
module gshare_pht_ctrl #(
  parameter int         IDX_WIDTH = 8,
  parameter int         PC_LSB    = 2,
  parameter logic [1:0] INIT_CTR  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // prediction interface (fetch)
  input  logic                 pred_req,
  input  logic [31:0]          pred_pc,
  output logic                 pred_ready,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [1:0]           pred_ctr,
  output logic [IDX_WIDTH-1:0] pred_ghr,
  // update interface (commit)
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [IDX_WIDTH-1:0] upd_ghr,
  input  logic [1:0]           upd_ctr,
  input  logic                 upd_taken,
  // SRAM port 0 (write)
  output logic                 pht_csb0,
  output logic [IDX_WIDTH-1:0] pht_addr0,
  output logic [1:0]           pht_din0,
  // SRAM port 1 (read)
  output logic                 pht_csb1,
  output logic [IDX_WIDTH-1:0] pht_addr1,
  input  logic [1:0]           pht_dout1
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q;
  logic [IDX_WIDTH-1:0] init_cnt_q;
  logic [IDX_WIDTH-1:0] ghr_q;
  logic [IDX_WIDTH-1:0] ghr_d;
  logic                 pred_vld_q;
  logic [IDX_WIDTH-1:0] pred_ghr_q;

  logic                 run;
  logic                 pred_acc;
  logic                 upd_acc;
  logic [IDX_WIDTH-1:0] pred_idx;
  logic [IDX_WIDTH-1:0] upd_idx;
  logic [1:0]           upd_new;
  logic [1:0]           ctr_sel;

  // Two-bit saturating counter step in the resolved direction.
  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  // Only the index slice of each PC is used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:PC_LSB+IDX_WIDTH], pred_pc[PC_LSB-1:0],
                            upd_pc[31:PC_LSB+IDX_WIDTH],  upd_pc[PC_LSB-1:0]};

  assign run      = (state_q == ST_RUN);
  assign pred_acc = rst_n && run && pred_req;
  assign upd_acc  = rst_n && run && upd_valid;
  assign pred_idx = pred_pc[PC_LSB +: IDX_WIDTH] ^ ghr_q;
  assign upd_idx  = upd_pc[PC_LSB +: IDX_WIDTH] ^ upd_ghr;
  assign upd_new  = sat_step(upd_ctr, upd_taken);

  // Next GHR: shift in the resolved direction of each accepted update.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_acc) begin
      ghr_d = {ghr_q[IDX_WIDTH-2:0], upd_taken};
    end
  end

  // Write port: the init sweep owns it during INIT, and updates own it in RUN.
  always_comb begin
    pht_csb0  = 1'b1;
    pht_addr0 = '0;
    pht_din0  = 2'b00;
    if (rst_n) begin
      if (!run) begin
        pht_csb0  = 1'b0;
        pht_addr0 = init_cnt_q;
        pht_din0  = INIT_CTR;
      end else if (upd_valid) begin
        pht_csb0  = 1'b0;
        pht_addr0 = upd_idx;
        pht_din0  = upd_new;
      end
    end
  end

  // Read port: the index uses the pre-shift GHR, even when an update shifts it this cycle.
  always_comb begin
    pht_csb1  = ~pred_acc;
    pht_addr1 = pred_idx;
  end

  // Control FSM: sweep INIT then stay in RUN; GHR and prediction-valid pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ghr_q      <= '0;
      pred_vld_q <= 1'b0;
      pred_ghr_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == {IDX_WIDTH{1'b1}}) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
      ghr_q      <= ghr_d;
      pred_vld_q <= pred_acc;
      if (pred_acc) begin
        pred_ghr_q <= ghr_q;
      end
    end
  end

`ifdef PHT_BYPASS_EN
  logic                 wr_vld_q;
  logic [IDX_WIDTH-1:0] wr_addr_q;
  logic [1:0]           wr_data_q;
  logic                 byp_hit_q;
  logic [1:0]           byp_data_q;
  logic                 hit_cur;
  logic                 hit_prev;

  assign hit_cur  = upd_acc  && (upd_idx   == pred_idx);
  assign hit_prev = wr_vld_q && (wr_addr_q == pred_idx);

  // Bypass control: remember last cycle's update and whether the read must be overridden.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_vld_q  <= 1'b0;
      byp_hit_q <= 1'b0;
    end else begin
      wr_vld_q  <= upd_acc;
      byp_hit_q <= pred_acc && (hit_cur || hit_prev);
    end
  end

  // Bypass data: the same-cycle update is younger than the previous one, so it wins.
  always_ff @(posedge clk) begin
    wr_addr_q  <= upd_idx;
    wr_data_q  <= upd_new;
    byp_data_q <= hit_cur ? upd_new : wr_data_q;
  end

  assign ctr_sel = byp_hit_q ? byp_data_q : pht_dout1;
`else
  assign ctr_sel = pht_dout1;
`endif

  assign pred_ready = run;
  assign pred_valid = pred_vld_q;
  assign pred_ctr   = pred_vld_q ? ctr_sel : 2'b00;
  assign pred_taken = pred_ctr[1];
  assign pred_ghr   = pred_ghr_q;

endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// Randomized bench for gshare_pht_ctrl. It includes a behavioural model of the
// PHT SRAM and keeps the reference table at branch level. Define PHT_BYPASS_EN
// for both the bench and the design when building the bypass variant.
module tb_gshare_pht_ctrl;
  localparam int IW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pred_req;
  logic [31:0]   pred_pc;
  logic          pred_ready;
  logic          pred_valid;
  logic          pred_taken;
  logic [1:0]    pred_ctr;
  logic [IW-1:0] pred_ghr;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic [IW-1:0] upd_ghr;
  logic [1:0]    upd_ctr;
  logic          upd_taken;
  logic          pht_csb0;
  logic [IW-1:0] pht_addr0;
  logic [1:0]    pht_din0;
  logic          pht_csb1;
  logic [IW-1:0] pht_addr1;
  logic [1:0]    pht_dout1;

  always #5 clk = ~clk;

  gshare_pht_ctrl #(.IDX_WIDTH(IW), .PC_LSB(2), .INIT_CTR(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_ready(pred_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
    .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_ctr(upd_ctr), .upd_taken(upd_taken),
    .pht_csb0(pht_csb0), .pht_addr0(pht_addr0), .pht_din0(pht_din0),
    .pht_csb1(pht_csb1), .pht_addr1(pht_addr1), .pht_dout1(pht_dout1)
  );

  // SRAM model: a write captured at edge N commits at edge N+1. The read
  // address is registered, and the read data is combinational from the array.
  logic [1:0]    mem [DEPTH];
  logic          pend_v;
  logic [IW-1:0] pend_a;
  logic [1:0]    pend_d;
  logic [IW-1:0] raddr;

  always @(posedge clk) begin
    if (pend_v) mem[pend_a] <= pend_d;
    pend_v <= ~pht_csb0;
    pend_a <= pht_addr0;
    pend_d <= pht_din0;
    if (!pht_csb1) raddr <= pht_addr1;
  end
  assign pht_dout1 = mem[raddr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model state
  bit            run_m;
  int            init_m;
  logic [IW-1:0] ghr_m;
  logic [1:0]    tbl [DEPTH];
  bit            exp_pv;
  logic [1:0]    exp_pctr;
  logic [IW-1:0] exp_pghr;
  bit            just_reset;

  function automatic logic [1:0] next_ctr(input logic [1:0] c, input bit t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic cycle(input bit rstn, input bit req, input logic [31:0] pc,
                       input bit uv, input logic [31:0] upc, input logic [IW-1:0] ughr,
                       input logic [1:0] uctr, input bit utk);
    logic [IW-1:0] pidx;
    logic [IW-1:0] uidx;
    logic [1:0]    unew;
    rst_n = rstn; pred_req = req; pred_pc = pc;
    upd_valid = uv; upd_pc = upc; upd_ghr = ughr; upd_ctr = uctr; upd_taken = utk;
    pidx = pc[9:2] ^ ghr_m;
    uidx = upc[9:2] ^ ughr;
    unew = next_ctr(uctr, utk);
    @(negedge clk);
    if (!rstn) begin
      check_eq("rst_csb0", pht_csb0, 1);
      check_eq("rst_csb1", pht_csb1, 1);
    end else begin
      check_eq("pred_valid", pred_valid, exp_pv);
      if (exp_pv) begin
        check_eq("pred_ctr", pred_ctr, exp_pctr);
        check_eq("pred_taken", pred_taken, exp_pctr[1]);
        check_eq("pred_ghr", pred_ghr, exp_pghr);
      end else begin
        check_eq("idle_ctr", pred_ctr, 0);
      end
      if (just_reset) check_eq("rst_pred_ghr", pred_ghr, 0);
      if (!run_m) begin
        check_eq("init_ready", pred_ready, 0);
        check_eq("init_csb0", pht_csb0, 0);
        check_eq("init_addr0", pht_addr0, init_m);
        check_eq("init_din0", pht_din0, 1);
        check_eq("init_csb1", pht_csb1, 1);
      end else begin
        check_eq("run_ready", pred_ready, 1);
        check_eq("csb1", pht_csb1, !req);
        if (req) check_eq("addr1", pht_addr1, pidx);
        check_eq("csb0", pht_csb0, !uv);
        if (uv) begin
          check_eq("addr0", pht_addr0, uidx);
          check_eq("din0", pht_din0, unew);
        end
      end
    end
    if (!rstn) begin
      run_m = 0; init_m = 0; ghr_m = '0; exp_pv = 0; exp_pghr = '0; just_reset = 1;
    end else if (!run_m) begin
      just_reset = 0;
      exp_pv = 0;
      if (init_m == DEPTH - 1) begin
        run_m = 1;
        foreach (tbl[i]) tbl[i] = 2'b01;
      end
      init_m++;
    end else begin
      just_reset = 0;
`ifdef PHT_BYPASS_EN
      if (uv) tbl[uidx] = unew;
`endif
      exp_pv = req;
      if (req) begin
        exp_pctr = tbl[pidx];
        exp_pghr = ghr_m;
      end
`ifndef PHT_BYPASS_EN
      if (uv) tbl[uidx] = unew;
`endif
      if (uv) ghr_m = {ghr_m[IW-2:0], utk};
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(1, 0, 32'h0, 0, 32'h0, '0, 2'b00, 0);
  endtask

  task automatic run_init();
    int guard = 0;
    while (!run_m && guard < 2 * DEPTH) begin
      cycle(1, 1'($urandom), $urandom, 1'($urandom), $urandom, IW'($urandom),
            2'($urandom), 1'($urandom));
      guard++;
    end
    check_eq("init_done", run_m, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [IW-1:0] prev_pidx;
    logic [31:0]   pc, upc;
    logic [IW-1:0] ughr, idx;
    bit            req, uv;
    pend_v = 0; raddr = '0;
    foreach (mem[i]) mem[i] = 2'($urandom);
    rst_n = 0; pred_req = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0;
    upd_ghr = 0; upd_ctr = 0; upd_taken = 0;
    run_m = 0; init_m = 0; ghr_m = 0; exp_pv = 0; exp_pctr = 0; exp_pghr = 0; just_reset = 0;
    @(posedge clk); #1;

    repeat (3) cycle(0, 0, 32'h0, 0, 32'h0, '0, 2'b00, 0);
    // abort the sweep at entry 100
    while (init_m != 100) idle();
    cycle(0, 0, 32'h0, 0, 32'h0, '0, 2'b00, 0);
    run_init();

    // first prediction, then saturating updates to index 0x04
    cycle(1, 1, 32'h10, 0, 32'h0, '0, 2'b00, 0);
    cycle(1, 0, 32'h0, 1, 32'h10, '0, 2'b01, 1);
    cycle(1, 0, 32'h0, 1, 32'h10, '0, 2'b10, 1);
    cycle(1, 0, 32'h0, 1, 32'h10, '0, 2'b11, 1);
    cycle(1, 1, 32'h0, 0, 32'h0, '0, 2'b00, 0);
    idle();
    check_eq("ghr_after_3_taken", pred_ghr, 8'h07);
    cycle(1, 0, 32'h0, 1, 32'h10, '0, 2'b00, 0);

    // randomized traffic with frequent index collisions
    prev_pidx = '0;
    for (int n = 0; n < 1500; n++) begin
      req  = 1'($urandom);
      uv   = 1'($urandom);
      pc   = $urandom;
      ughr = IW'($urandom);
      case ($urandom_range(0, 2))
        0: idx = pc[9:2] ^ ghr_m ^ ughr;
        1: idx = prev_pidx ^ ughr;
        default: idx = IW'($urandom);
      endcase
      upc = ($urandom & 32'hFFFF_FC03) | ({24'h0, idx} << 2);
      prev_pidx = pc[9:2] ^ ghr_m;
      cycle(1, req, pc, uv, upc, ughr, 2'($urandom), 1'($urandom));
    end

    // reset in RUN with a prediction in flight
    cycle(1, 1, 32'h0000_1234, 1, 32'h10, '0, 2'b01, 1);
    cycle(0, 1, 32'h0000_5678, 1, 32'h20, '0, 2'b01, 1);
    run_init();

    // same-cycle collision: GHR=0x07 built through index 0x08
    repeat (3) cycle(1, 0, 32'h0, 1, 32'h20, '0, 2'b01, 1);
    cycle(1, 1, 32'h40C, 1, 32'h10, '0, 2'b01, 1);
    #3;
`ifdef PHT_BYPASS_EN
    check_eq("collide_ctr", pred_ctr, 2'b10);
`else
    check_eq("collide_ctr", pred_ctr, 2'b01);
`endif
    check_eq("collide_ghr", pred_ghr, 8'h07);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
